// File: rtl/div_ctrl_pkg.sv
// Shared ALU definitions for the divider: operator codes, FSM encoding, helpers.
// Optional build macro DIV_CTRL_BYPASS_EN (see div_ctrl.sv).
package div_ctrl_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned CntWidth  = 6;

    // ALU operator codes (5-bit operator field)
    localparam logic [4:0] AluAdd    = 5'd0;
    localparam logic [4:0] AluSub    = 5'd1;
    localparam logic [4:0] AluXor    = 5'd2;
    localparam logic [4:0] AluOr     = 5'd3;
    localparam logic [4:0] AluAnd    = 5'd4;
    localparam logic [4:0] AluSll    = 5'd5;
    localparam logic [4:0] AluSrl    = 5'd6;
    localparam logic [4:0] AluSra    = 5'd7;
    localparam logic [4:0] AluSlt    = 5'd8;
    localparam logic [4:0] AluSltu   = 5'd9;
    localparam logic [4:0] AluMul    = 5'd10;
    localparam logic [4:0] AluMulh   = 5'd11;
    localparam logic [4:0] AluDiv    = 5'd12;
    localparam logic [4:0] AluDivu   = 5'd13;
    localparam logic [4:0] AluRem    = 5'd14;
    localparam logic [4:0] AluRemu   = 5'd15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == AluDiv) || (op == AluDivu) || (op == AluRem) || (op == AluRemu);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == AluDiv) || (op == AluRem);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == AluRem) || (op == AluRemu);
    endfunction

    function automatic logic [DataWidth-1:0] abs_val(input logic [DataWidth-1:0] v);
        return v[DataWidth-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response handshake bundle between a requester and div_ctrl.
interface div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       operator;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output req_valid, operator, operand1, operand2, resp_ready,
        input  req_ready, resp_valid, result
    );

    modport slave (
        input  req_valid, operator, operand1, operand2, resp_ready,
        output req_ready, resp_valid, result
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, select.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction on a WIDTH+1 window; a borrow means the bit is zero.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (diff[WIDTH]) begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_ctrl.sv
// Sequential 32-bit divider controller (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Macro DIV_CTRL_BYPASS_EN: divide-by-zero and signed overflow skip the iteration.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    output logic         busy,
    div_ctrl_if.slave    bus
);
    div_state_e           state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [4:0]           op_q, op_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     op1_q, op1_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 div0_q, div0_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     step_rem, step_quo;
    logic [WIDTH-1:0]     q_fix, r_fix;
    logic                 in_signed;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Next-state: latch operands on accept, iterate in CALC, hand off in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op1_d     = op1_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        in_signed = is_signed_op(bus.operator);

        unique case (state_q)
            StIdle: begin
                // Non-divide operators complete the handshake but are ignored.
                if (bus.req_valid && is_div_op(bus.operator)) begin
                    op_d    = bus.operator;
                    op1_d   = bus.operand1;
                    rem_d   = '0;
                    quo_d   = in_signed ? abs_val(bus.operand1) : bus.operand1;
                    dvs_d   = in_signed ? abs_val(bus.operand2) : bus.operand2;
                    negq_d  = in_signed && (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
                    negr_d  = in_signed && bus.operand1[WIDTH-1];
                    div0_d  = (bus.operand2 == '0);
                    ovf_d   = in_signed && (bus.operand1 == 32'h8000_0000)
                              && (bus.operand2 == 32'hFFFF_FFFF);
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
`ifdef DIV_CTRL_BYPASS_EN
                // Special cases have fixed results; leave after a single cycle.
                if (div0_q || ovf_q) begin
                    state_d = StDone;
                end else
`endif
                if (cnt_q == CntWidth'(WIDTH)) begin
                    state_d = StDone;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over any handshake in the same cycle.
        if (flush) begin
            state_d = StIdle;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            op1_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            op1_q   <= op1_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs: sign fix and special-case override; result is zero outside DONE.
    always_comb begin
        q_fix = negq_q ? (~quo_q + 1'b1) : quo_q;
        r_fix = negr_q ? (~rem_q + 1'b1) : rem_q;
        if (div0_q) begin
            q_fix = '1;
            r_fix = op1_q;
        end else if (ovf_q) begin
            q_fix = 32'h8000_0000;
            r_fix = '0;
        end
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StDone);
        busy           = (state_q != StIdle);
        bus.result     = (state_q == StDone) ? (is_rem_op(op_q) ? r_fix : q_fix) : '0;
    end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 operator  input  5  ALU operator code; only DIV/DIVU/REM/REMU are serviced.
REQ-007 operand1  input  32  dividend.
REQ-008 operand2  input  32  divisor.
REQ-009 resp_valid  output  1  result present.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 result  output  32  quotient or remainder.
REQ-012 flush  input  1  abort any in-flight operation.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid&&req_ready.
REQ-016 Accepting a request whose operator is not one of the four divide codes SHALL leave the FSM in IDLE and produce no response.
REQ-017 On accept, the block SHALL latch the operator, the absolute values (signed ops) or raw values (unsigned ops), and the result sign flags, then enter CALC.
REQ-018 CALC SHALL perform one restoring quotient bit per cycle for exactly 32 cycles, using a 6-bit counter, then enter DONE.
REQ-019 Quotient sign: negative iff the operand signs differ; remainder sign: that of the dividend; signs apply to DIV/REM only.
REQ-020 Divide by zero SHALL return quotient 32'hFFFFFFFF (no sign fix) and remainder = operand1, for both signed and unsigned ops.
REQ-021 Signed overflow (32'h80000000 / 32'hFFFFFFFF) SHALL return quotient 32'h80000000 and remainder 0.
REQ-022 In DONE, resp_valid SHALL be 1 and result SHALL be stable until resp_ready; on resp_valid&&resp_ready the FSM SHALL return to IDLE.
REQ-023 Latency: a request accepted at edge t SHALL have resp_valid high from edge t+33, with no early-out (macro excepted).
REQ-024 flush SHALL force IDLE at the next edge from any state, discard the result and override a simultaneous req_valid or resp_ready.
REQ-025 result SHALL be 0 whenever resp_valid is 0.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, result=0, resp_valid=0, busy=0 and req_ready=1, regardless of the clock.
REQ-027 rst asserted mid-CALC or mid-DONE SHALL drop the operation with no response.

Configuration
REQ-028 Macro DIV_CTRL_BYPASS_EN SHALL control the special-case bypass.
REQ-029 With DIV_CTRL_BYPASS_EN defined, divide by zero and signed overflow SHALL skip CALC and go straight to DONE, so resp_valid rises at t+1.
REQ-030 Without DIV_CTRL_BYPASS_EN, these cases SHALL take the full 33-cycle latency with results identical to REQ-020/021.

Structure
REQ-031 Operator codes and the FSM state encoding SHALL live in the shared define file, alongside the existing ALU operator constants.
REQ-032 The single-bit restoring step (shift, subtract, select) SHALL be a sub-module div_step; sequencing and sign fix SHALL stay in div_ctrl.

Verification
REQ-033 DIVU 100/7 -> result 14 at t+33; REMU 100/7 -> result 2.
REQ-034 DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF.
REQ-035 DIV 5/0 -> 32'hFFFFFFFF and REM 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000. Check latency t+1 with the macro defined and t+33 without.
REQ-036 DIVU 10/3 with resp_ready held low for 5 cycles -> result 3 held stable with resp_valid=1; req_ready=0 throughout.
REQ-037 flush at CALC cycle 10 -> IDLE next cycle and no resp_valid; a new DIVU 9/3 then returns 3.
REQ-038 rst pulse mid-CALC -> all outputs at reset values immediately; operator ADD accepted -> no response and busy=0.
